ifu_fetch_stage: RTL

Instruction fetch stage that feeds the decode stage.
- Holds the architectural PC.
- Issues one instruction read per instruction over a valid/ready address/data bus.
- Presents the fetched word and its PC to decode with a valid/ready handshake.
- Waits for the commit stage to supply the next PC before starting the next fetch. The core is single-issue and multi-cycle, with no speculation.

---
 rtl/ifu_fetch_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch_stage.sv
// ---------------------------------------------------------------------------
// ifu_fetch_stage
//
// Instruction fetch stage for a single-issue, multi-cycle, non-speculative
// core. It holds the architectural PC and issues one instruction read per
// instruction. It presents the fetched word and its PC to decode, then waits
// for commit to supply the next PC before it fetches again.
//
// Handshakes: a transfer happens on a clk edge where valid and ready are both
// high. A valid, once raised, stays high with its payload stable until the
// transfer completes. All valids here decode from the state register only, so
// they are Moore outputs. A ready/valid from a partner in any other state is
// ignored.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_ar*          read-address channel (araddr is always pc)
//   imem_r*           read-data channel
//   inst, pc          fetched instruction and its PC to decode
//   ifu_valid         inst/pc valid to decode; idu_ready is decode's accept
//   commit_valid/npc  retirement of the current instruction plus next PC
//   fetch_err         sticky misaligned-PC flag (0 unless checking enabled)
//
// Configuration macro: IFU_ALIGN_CHECK_EN
//   defined   - a misaligned commit_npc sets fetch_err, records the PC and
//               parks the stage in S_WAIT until reset
//   undefined - the low two bits of commit_npc are masked and fetch goes on
// ---------------------------------------------------------------------------
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        ifu_valid,
    input  logic        idu_ready,
    input  logic        commit_valid,
    input  logic [31:0] commit_npc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

`ifdef IFU_ALIGN_CHECK_EN
    logic err_q, err_d;
    logic npc_misaligned;

`ifndef SYNTHESIS
    function automatic void set_npc_state(input int state, input int code);
        $display("ifu_fetch_stage: set_npc_state(%0d,%0d) misaligned npc %h",
                 state, code, commit_npc);
    endfunction
`endif

    assign npc_misaligned = (commit_npc[1:0] != 2'b00);
`else
    // The low PC bits are deliberately discarded when checking is disabled.
    logic unused_npc_low;
    assign unused_npc_low = ^commit_npc[1:0];
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef IFU_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_REQ: begin
                if (imem_arready) state_d = S_RESP;
            end
            S_RESP: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (idu_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef IFU_ALIGN_CHECK_EN
                // Once the error is set, the stage never fetches again.
                if (commit_valid && !err_q) begin
                    pc_d = commit_npc;
                    if (npc_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
`else
                if (commit_valid) begin
                    pc_d    = {commit_npc[31:2], 2'b00};
                    state_d = S_REQ;
                end
`endif
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
`ifdef IFU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
`ifdef IFU_ALIGN_CHECK_EN
            err_q   <= err_d;
`ifndef SYNTHESIS
            if (state_q == S_WAIT && commit_valid && !err_q && npc_misaligned)
                set_npc_state(3, 0);
`endif
`endif
        end
    end

    // Moore outputs. Reset overrides them so nothing handshakes while in reset.
    assign imem_arvalid = !rst && (state_q == S_REQ);
    assign imem_rready  = !rst && (state_q == S_RESP);
    assign ifu_valid    = !rst && (state_q == S_OUT);
    assign imem_araddr  = pc_q;
    assign pc           = pc_q;
    assign inst         = inst_q;

`ifdef IFU_ALIGN_CHECK_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
